// File: rtl/pc_pkg.sv
// Shared types and widths for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_IDLE,
    PC_RUN,
    PC_DONE
  } pc_state_t;

  localparam int PC_W  = 12;
  localparam int CNT_W = 16;

  // Saturating increment for the retired-instruction counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    res = val;
    if (val != {CNT_W{1'b1}}) begin
      res = val + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC computation: increment, relative branch or absolute
// jump, plus a check of the result against the instruction-memory depth.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int D        = PC_W,
  parameter int PROG_LEN = 1024
) (
  input  logic [D-1:0] pc,
  input  logic [D-1:0] target,
  input  logic         branch_taken,
  input  logic         branch_abs,
  output logic [D-1:0] next_pc,
  output logic         out_of_range
);

  // Upper bound of the legal PC range, one bit wider so 2**D is representable.
  localparam logic [D:0] LIMIT = (D+1)'(PROG_LEN);

  // Relative targets are two's complement, so a plain D-bit modular add covers
  // both forward and backward branches.
  always_comb begin
    next_pc = pc + {{(D-1){1'b0}}, 1'b1};
    if (branch_taken && branch_abs) begin
      next_pc = target;
    end else if (branch_taken) begin
      next_pc = pc + target;
    end
  end

  // When PROG_LEN equals 2**D this comparison is constant-false and wrap is legal.
  always_comb begin
    out_of_range = ({1'b0, next_pc} >= LIMIT);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the fetch PC, runs the Start/Done handshake
// with the harness, counts retired instructions and flags out-of-range targets.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int D        = PC_W,
  parameter int PROG_LEN = 1024,
  parameter int START_PC = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Branch_taken,
  input  logic             Branch_abs,
  input  logic [D-1:0]     Target,
  input  logic             Halt,
  output logic [D-1:0]     Prog_ctr,
  output logic             Fetch_valid,
  output logic             Done,
  output logic             Fault,
  output logic [CNT_W-1:0] Instr_cnt
);

  localparam logic [D-1:0] START_VAL = D'(START_PC);

  pc_state_t        state_q, state_d;
  logic [D-1:0]     pc_q, pc_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [D-1:0]     next_pc;
  logic             out_of_range;

  pc_next_calc #(
    .D        (D),
    .PROG_LEN (PROG_LEN)
  ) u_next_calc (
    .pc           (pc_q),
    .target       (Target),
    .branch_taken (Branch_taken),
    .branch_abs   (Branch_abs),
    .next_pc      (next_pc),
    .out_of_range (out_of_range)
  );

  // Next-state decode: Start restarts from IDLE or DONE, RUN retires one
  // instruction per unstalled cycle with Halt taking priority over branches.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PC_IDLE, PC_DONE: begin
        if (Start) begin
          state_d = PC_RUN;
          pc_d    = START_VAL;
          done_d  = 1'b0;
          fault_d = 1'b0;
          cnt_d   = '0;
        end
      end
      PC_RUN: begin
        if (!Stall) begin
          cnt_d = sat_inc(cnt_q);
          if (Halt) begin
            state_d = PC_DONE;
            done_d  = 1'b1;
          end else if (out_of_range) begin
            state_d = PC_DONE;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end else begin
            pc_d = next_pc;
          end
        end
      end
      default: begin
        state_d = PC_IDLE;
      end
    endcase
  end

  // State, PC, flags and counter registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= PC_IDLE;
      pc_q    <= START_VAL;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Prog_ctr    = pc_q;
  assign Done        = done_q;
  assign Fault       = fault_q;
  assign Instr_cnt   = cnt_q;
  assign Fetch_valid = (state_q == PC_RUN);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: two instances (PROG_LEN 1024 and 4096) share the
// same stimulus; expected outputs are queued per instance and compared after
// each rising edge.
module tb_pc_sequencer;

  logic        Clk;
  logic        Reset_n;
  logic        Start;
  logic        Stall;
  logic        Branch_taken;
  logic        Branch_abs;
  logic [11:0] Target;
  logic        Halt;

  logic [11:0] pcA, pcB;
  logic        fvA, fvB, doneA, doneB, faultA, faultB;
  logic [15:0] cntA, cntB;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          st;
    logic [11:0] pc;
    logic        done;
    logic        fault;
    logic [15:0] cnt;
  } mdl_t;

  mdl_t mA, mB;
  mdl_t expA[$];
  mdl_t expB[$];

  pc_sequencer #(.D(12), .PROG_LEN(1024), .START_PC(0)) dutA (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .Branch_taken(Branch_taken), .Branch_abs(Branch_abs), .Target(Target),
    .Halt(Halt), .Prog_ctr(pcA), .Fetch_valid(fvA), .Done(doneA),
    .Fault(faultA), .Instr_cnt(cntA)
  );

  pc_sequencer #(.D(12), .PROG_LEN(4096), .START_PC(0)) dutB (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall),
    .Branch_taken(Branch_taken), .Branch_abs(Branch_abs), .Target(Target),
    .Halt(Halt), .Prog_ctr(pcB), .Fetch_valid(fvB), .Done(doneB),
    .Fault(faultB), .Instr_cnt(cntB)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference behaviour: 0=IDLE, 1=RUN, 2=DONE.
  function automatic mdl_t modelReset();
    mdl_t m;
    m.st = 0; m.pc = 12'd0; m.done = 1'b0; m.fault = 1'b0; m.cnt = 16'd0;
    return m;
  endfunction

  function automatic mdl_t modelStep(mdl_t m, int plen, logic st, logic sl,
                                     logic bt, logic ba, logic [11:0] tg, logic hl);
    mdl_t r;
    logic [11:0] np;
    r = m;
    if (m.st != 1) begin
      if (st) begin
        r.st = 1; r.pc = 12'd0; r.cnt = 16'd0; r.done = 1'b0; r.fault = 1'b0;
      end
    end else if (!sl) begin
      if (m.cnt != 16'hFFFF) r.cnt = m.cnt + 16'd1;
      if (hl) begin
        r.st = 2; r.done = 1'b1;
      end else begin
        if (bt && ba) np = tg;
        else if (bt)  np = m.pc + tg;
        else          np = m.pc + 12'd1;
        if (int'(np) >= plen) begin
          r.st = 2; r.done = 1'b1; r.fault = 1'b1;
        end else begin
          r.pc = np;
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic compareOne(input string who, input mdl_t e, input logic [11:0] pc,
                            input logic fv, input logic dn, input logic ft,
                            input logic [15:0] cnt);
    checkOutput({who, ".pc"},    32'(pc),  32'(e.pc));
    checkOutput({who, ".fv"},    32'(fv),  32'(e.st == 1));
    checkOutput({who, ".done"},  32'(dn),  32'(e.done));
    checkOutput({who, ".fault"}, 32'(ft),  32'(e.fault));
    checkOutput({who, ".cnt"},   32'(cnt), 32'(e.cnt));
  endtask

  task automatic popAndCompare();
    mdl_t e;
    if (expA.size() == 0 || expB.size() == 0) begin
      checkOutput("queue_empty", 32'd1, 32'd0);
    end else begin
      e = expA.pop_front();
      compareOne("A", e, pcA, fvA, doneA, faultA, cntA);
      e = expB.pop_front();
      compareOne("B", e, pcB, fvB, doneB, faultB, cntB);
    end
  endtask

  // One clock of stimulus: drive, predict, clock, then compare.
  task automatic applyStimulus(input logic st, input logic sl, input logic bt,
                               input logic ba, input logic [11:0] tg, input logic hl);
    Start = st; Stall = sl; Branch_taken = bt; Branch_abs = ba; Target = tg; Halt = hl;
    mA = modelStep(mA, 1024, st, sl, bt, ba, tg, hl);
    mB = modelStep(mB, 4096, st, sl, bt, ba, tg, hl);
    expA.push_back(mA);
    expB.push_back(mB);
    @(posedge Clk);
    #1;
    Start = 1'b0; Stall = 1'b0; Branch_taken = 1'b0; Branch_abs = 1'b0;
    Target = 12'd0; Halt = 1'b0;
    popAndCompare();
  endtask

  task automatic plain();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
  endtask

  task automatic jumpAbs(input logic [11:0] tg);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, tg, 1'b0);
  endtask

  task automatic jumpRel(input logic [11:0] tg);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, tg, 1'b0);
  endtask

  task automatic startPulse();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
  endtask

  task automatic haltNow();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1);
  endtask

  initial begin
    Reset_n = 1'b0;
    Start = 1'b0; Stall = 1'b0; Branch_taken = 1'b0; Branch_abs = 1'b0;
    Target = 12'd0; Halt = 1'b0;
    mA = modelReset();
    mB = modelReset();
    #12;
    expA.push_back(mA);
    expB.push_back(mB);
    popAndCompare();
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Start then four sequential fetches: PC 0,1,2,3,4 and count 4.
    startPulse();
    for (int i = 0; i < 4; i++) plain();

    // Backward relative branches from PC 10.
    jumpAbs(12'd10);
    jumpRel(12'hFFB);
    jumpRel(12'hFFF);

    // Absolute branch to 20 from PC 3, first while stalled.
    jumpAbs(12'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 12'd20, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 1'b0);
    jumpAbs(12'd20);

    // Past the end of a 1024-deep program faults A; B continues to 1030.
    jumpAbs(12'd1000);
    jumpRel(12'd30);
    plain();
    haltNow();
    startPulse();

    // Wrap from PC 0 by -1: fault for A, legal 4095 for B.
    jumpRel(12'hFFF);
    plain();
    haltNow();
    startPulse();

    // Halt wins over a simultaneous branch; Start while running is ignored.
    jumpAbs(12'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 12'd100, 1'b1);
    plain();
    startPulse();

    // Relative target of zero re-executes the same PC.
    jumpRel(12'd0);
    jumpRel(12'd0);

    // Asynchronous reset while running at PC 9, observed before the next edge.
    jumpAbs(12'd9);
    #2;
    Reset_n = 1'b0;
    #1;
    mA = modelReset();
    mB = modelReset();
    expA.push_back(mA);
    expB.push_back(mB);
    popAndCompare();
    #2;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    plain();
    startPulse();
    plain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
